// File: rtl/riscv_pkg.sv
// Shared barrel-core constants and the PC-writer state type.
package riscv_pkg;

    localparam int unsigned DWIDTH       = 32;
    localparam int unsigned NUM_THREADS  = 16;
    localparam int unsigned PC_BITS      = 12;
    localparam logic [31:0] STARTUP_ADDR = 32'h0000_0000;

    typedef enum logic {
        PCW_INIT = 1'b0,
        PCW_RUN  = 1'b1
    } pcw_state_e;

endpackage

// File: rtl/pc_next_writer.sv
// Write-side producer for the per-thread PC store: init sweep after reset, then one
// registered PC write per execute beat (redirect > taken branch > PC+4).
module pc_next_writer
    import riscv_pkg::*;
#(
    parameter int unsigned DWIDTH                    = riscv_pkg::DWIDTH,
    parameter int unsigned NUM_THREADS               = riscv_pkg::NUM_THREADS,
    parameter int unsigned PC_BITS                   = riscv_pkg::PC_BITS,
    parameter logic [DWIDTH-1:0] STARTUP_ADDR        = DWIDTH'(riscv_pkg::STARTUP_ADDR),
    localparam int unsigned TW                       = $clog2(NUM_THREADS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [TW-1:0]      i_tid_ex,
    input  logic [DWIDTH-1:0]  i_pc_ex,
    input  logic               i_br_taken,
    input  logic [DWIDTH-1:0]  i_br_target,
    input  logic               i_redir_valid,
    input  logic [TW-1:0]      i_redir_tid,
    input  logic [DWIDTH-1:0]  i_redir_pc,
    output logic               o_redir_ready,
    output logic               o_we,
    output logic [TW-1:0]      o_waddr,
    output logic [PC_BITS-1:0] o_wdata,
    output logic               o_misalign,
    output logic               o_init_done
);

    localparam logic [PC_BITS-1:0] STARTUP_PC = STARTUP_ADDR[PC_BITS-1:0];
    localparam logic [TW-1:0]      LAST_SLOT  = TW'(NUM_THREADS - 1);

    pcw_state_e         state_r;
    pcw_state_e         state_s;
    logic [TW-1:0]      ctr_r;
    logic [TW-1:0]      ctr_s;
    logic               we_s;
    logic [TW-1:0]      waddr_s;
    logic [PC_BITS-1:0] wdata_s;
    logic               ready_s;
    logic               misalign_s;
    logic               done_s;
    logic               redir_hit_s;
    logic [DWIDTH-1:0]  pc_plus4_s;
    logic [DWIDTH-1:0]  sel_s;

    assign pc_plus4_s = i_pc_ex + DWIDTH'(32'd4);

    // The ready pulse still being high means the held request was just consumed;
    // blocking it here prevents a second take before the requester drops valid.
    assign redir_hit_s = i_redir_valid && !o_redir_ready && (i_redir_tid == i_tid_ex);

    // Next-state, sweep counter and next-PC selection.
    always_comb begin
        state_s    = state_r;
        ctr_s      = ctr_r;
        we_s       = 1'b0;
        waddr_s    = o_waddr;
        wdata_s    = o_wdata;
        ready_s    = 1'b0;
        misalign_s = 1'b0;
        done_s     = o_init_done;
        sel_s      = pc_plus4_s;
        case (state_r)
            PCW_INIT: begin
                we_s    = 1'b1;
                waddr_s = ctr_r;
                wdata_s = STARTUP_PC;
                ctr_s   = ctr_r + TW'(1);
                if (ctr_r == LAST_SLOT) begin
                    state_s = PCW_RUN;
                end else begin
                    state_s = PCW_INIT;
                end
            end
            PCW_RUN: begin
                done_s = 1'b1;
                if (i_valid) begin
                    if (redir_hit_s) begin
                        sel_s   = i_redir_pc;
                        ready_s = 1'b1;
                    end else if (i_br_taken) begin
                        sel_s = i_br_target;
                    end else begin
                        sel_s = pc_plus4_s;
                    end
                    we_s       = 1'b1;
                    waddr_s    = i_tid_ex;
                    wdata_s    = sel_s[PC_BITS-1:0];
                    misalign_s = (sel_s[1:0] != 2'b00);
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                state_s = PCW_INIT;
                ctr_s   = '0;
            end
        endcase
    end

    // State, counter and registered write-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= PCW_INIT;
            ctr_r         <= '0;
            o_we          <= 1'b0;
            o_waddr       <= '0;
            o_wdata       <= '0;
            o_redir_ready <= 1'b0;
            o_misalign    <= 1'b0;
            o_init_done   <= 1'b0;
        end else begin
            state_r       <= state_s;
            ctr_r         <= ctr_s;
            o_we          <= we_s;
            o_waddr       <= waddr_s;
            o_wdata       <= wdata_s;
            o_redir_ready <= ready_s;
            o_misalign    <= misalign_s;
            o_init_done   <= done_s;
        end
    end

endmodule

// File: tb/tb_pc_next_writer.sv
// Self-checking bench for pc_next_writer: expected write-port records are queued as
// stimulus is driven and compared one cycle later.
module tb_pc_next_writer;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [3:0]  i_tid_ex;
    logic [31:0] i_pc_ex;
    logic        i_br_taken;
    logic [31:0] i_br_target;
    logic        i_redir_valid;
    logic [3:0]  i_redir_tid;
    logic [31:0] i_redir_pc;
    logic        o_redir_ready;
    logic        o_we;
    logic [3:0]  o_waddr;
    logic [11:0] o_wdata;
    logic        o_misalign;
    logic        o_init_done;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [11:0] data;
        logic        ready;
        logic        mis;
        logic        done;
    } exp_t;

    typedef struct {
        string       name;
        logic [3:0]  tid;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [11:0] data;
        logic        mis;
        logic        idle_after;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          total = 0;
    int          bad   = 0;
    logic        exp_done;
    logic [3:0]  last_addr;
    logic [11:0] last_data;

    pc_next_writer dut (
        .clk           (clk),
        .reset         (reset),
        .i_valid       (i_valid),
        .i_tid_ex      (i_tid_ex),
        .i_pc_ex       (i_pc_ex),
        .i_br_taken    (i_br_taken),
        .i_br_target   (i_br_target),
        .i_redir_valid (i_redir_valid),
        .i_redir_tid   (i_redir_tid),
        .i_redir_pc    (i_redir_pc),
        .o_redir_ready (o_redir_ready),
        .o_we          (o_we),
        .o_waddr       (o_waddr),
        .o_wdata       (o_wdata),
        .o_misalign    (o_misalign),
        .o_init_done   (o_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t sample();
        exp_t a;
        a = {o_we, o_waddr, o_wdata, o_redir_ready, o_misalign, o_init_done};
        return a;
    endfunction

    task automatic check(input string name, input exp_t a, input exp_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got we=%0b addr=%0d data=%h ready=%0b mis=%0b done=%0b, want we=%0b addr=%0d data=%h ready=%0b mis=%0b done=%0b",
                     name, a.we, a.addr, a.data, a.ready, a.mis, a.done,
                     e.we, e.addr, e.data, e.ready, e.mis, e.done);
        end
    endtask

    task automatic expect_write(input logic [3:0] addr, input logic [11:0] data,
                                input logic ready, input logic mis);
        sb.push_back('{we: 1'b1, addr: addr, data: data, ready: ready, mis: mis, done: exp_done});
        last_addr = addr;
        last_data = data;
    endtask

    task automatic expect_idle();
        sb.push_back('{we: 1'b0, addr: last_addr, data: last_data, ready: 1'b0, mis: 1'b0, done: exp_done});
    endtask

    task automatic expect_reset();
        last_addr = 4'd0;
        last_data = 12'h000;
        sb.push_back('{we: 1'b0, addr: 4'd0, data: 12'h000, ready: 1'b0, mis: 1'b0, done: 1'b0});
    endtask

    task automatic tick(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got we=%0b", name, o_we);
        end else begin
            e = sb.pop_front();
            check(name, sample(), e);
        end
    endtask

    task automatic set_beat(input logic v, input logic [3:0] tid, input logic [31:0] pc,
                            input logic taken, input logic [31:0] target);
        i_valid     = v;
        i_tid_ex    = tid;
        i_pc_ex     = pc;
        i_br_taken  = taken;
        i_br_target = target;
    endtask

    task automatic set_redir(input logic v, input logic [3:0] tid, input logic [31:0] pc);
        i_redir_valid = v;
        i_redir_tid   = tid;
        i_redir_pc    = pc;
    endtask

    initial begin
        vecs[0] = '{"seq_plus4",    4'd5,  32'h0000_0100, 1'b0, 32'h0,          12'h104, 1'b0, 1'b1};
        vecs[1] = '{"taken",        4'd3,  32'h0000_0200, 1'b1, 32'h0000_03F0,  12'h3F0, 1'b0, 1'b0};
        vecs[2] = '{"taken_mis",    4'd3,  32'h0000_0200, 1'b1, 32'h0000_03F2,  12'h3F2, 1'b1, 1'b1};
        vecs[3] = '{"wrap",         4'd1,  32'h0000_0FFC, 1'b0, 32'h0,          12'h000, 1'b0, 1'b0};
        vecs[4] = '{"truncate",     4'd4,  32'h1234_5678, 1'b0, 32'h0,          12'h67C, 1'b0, 1'b1};
        vecs[5] = '{"upper_drop",   4'd15, 32'h0000_0000, 1'b1, 32'hABCD_E001,  12'h001, 1'b1, 1'b0};
        vecs[6] = '{"seq_mis",      4'd0,  32'h0000_07FE, 1'b0, 32'h0,          12'h802, 1'b1, 1'b0};
        vecs[7] = '{"taken_low",    4'd6,  32'h0000_1000, 1'b1, 32'h0000_0010,  12'h010, 1'b0, 1'b1};

        reset    = 1'b1;
        exp_done = 1'b0;
        set_beat(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        set_redir(1'b0, 4'd0, 32'h0);

        repeat (3) begin
            expect_reset();
            tick("reset");
        end
        reset = 1'b0;

        // Partial sweep, then reset arrives between edges while slot 7 is showing.
        for (int i = 0; i < 8; i++) begin
            expect_write(4'(i), 12'h000, 1'b0, 1'b0);
            tick("sweep_partial");
        end
        reset = 1'b1;
        #1;
        check("async_reset", sample(), exp_t'(0));
        last_addr = 4'd0;
        last_data = 12'h000;
        repeat (2) begin
            expect_reset();
            tick("reset_hold");
        end

        // Beat and matching redirect held through the whole sweep must be ignored there.
        set_beat(1'b1, 4'd2, 32'h0000_0040, 1'b0, 32'h0);
        set_redir(1'b1, 4'd2, 32'h0000_00C0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expect_write(4'(i), 12'h000, 1'b0, 1'b0);
            tick("sweep_full");
        end
        exp_done = 1'b1;
        expect_write(4'd2, 12'h0C0, 1'b1, 1'b0);
        tick("init_redirect");
        set_redir(1'b0, 4'd0, 32'h0);
        set_beat(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        expect_idle();
        tick("idle_hold");

        for (int i = 0; i < 8; i++) begin
            set_beat(1'b1, vecs[i].tid, vecs[i].pc, vecs[i].taken, vecs[i].target);
            expect_write(vecs[i].tid, vecs[i].data, 1'b0, vecs[i].mis);
            tick(vecs[i].name);
            if (vecs[i].idle_after) begin
                set_beat(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
                expect_idle();
                tick({vecs[i].name, "_idle"});
            end
        end

        // Held redirect waits through non-matching beats and idle cycles.
        set_redir(1'b1, 4'd9, 32'h0000_0080);
        set_beat(1'b1, 4'd7, 32'h0000_0300, 1'b0, 32'h0);
        expect_write(4'd7, 12'h304, 1'b0, 1'b0);
        tick("redir_wait_t7");
        set_beat(1'b1, 4'd8, 32'h0000_0400, 1'b1, 32'h0000_0444);
        expect_write(4'd8, 12'h444, 1'b0, 1'b0);
        tick("redir_wait_t8");
        set_beat(1'b0, 4'd9, 32'h0000_0500, 1'b0, 32'h0);
        expect_idle();
        tick("redir_wait_idle");
        set_beat(1'b1, 4'd9, 32'h0000_0500, 1'b1, 32'h0000_0500);
        expect_write(4'd9, 12'h080, 1'b1, 1'b0);
        tick("redir_take");
        set_redir(1'b0, 4'd0, 32'h0);
        set_beat(1'b1, 4'd9, 32'h0000_0600, 1'b0, 32'h0);
        expect_write(4'd9, 12'h604, 1'b0, 1'b0);
        tick("redir_after");

        set_redir(1'b1, 4'd2, 32'h0000_00FE);
        set_beat(1'b1, 4'd2, 32'h0000_0100, 1'b1, 32'h0000_0200);
        expect_write(4'd2, 12'h0FE, 1'b1, 1'b1);
        tick("redir_mis");
        set_redir(1'b0, 4'd0, 32'h0);
        set_beat(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        expect_idle();
        tick("final_idle");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
